// File: rtl/mem_bus_pkg.sv
// Shared types and sizing helpers for the memory-bus responder.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    // Width of a down-counter able to hold wait_cycles, never narrower than one bit.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM: write-enable, registered read with read-enable.
module sync_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH) - 1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // NOTE: the array and its read register carry no reset so the storage maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bus_responder.sv
// Responder end of the CPU memory bus: captures a request, counts wait states,
// commits the RAM access and returns a registered one-cycle ready pulse.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] memory_address,
    input  logic [DATA_WIDTH-1:0] memory_in,
    input  logic                  memory_read_signal,
    input  logic                  memory_write_signal,
    output logic [DATA_WIDTH-1:0] memory_out,
    output logic                  memory_ready,
    output logic                  busy,
    output logic                  protocol_error
);

    localparam int               CNT_W     = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam bit               ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_perr;
    logic                  r_rd_valid;

    logic                  w_req;
    logic                  w_capture;
    logic                  w_commit;
    logic                  w_is_write;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_req     = memory_read_signal | memory_write_signal;
    assign w_capture = (r_state == IDLE) && w_req;

    // With no wait states the access commits on the capture edge straight from the bus;
    // otherwise it commits from the latched fields on the last WAIT edge. Reset abandons it.
    assign w_commit    = !reset &&
                         ((ZERO_WAIT && w_capture) ||
                          ((r_state == WAIT) && w_req && (r_cnt == CNT_LAST)));
    assign w_is_write  = (r_state == IDLE) ? memory_write_signal : r_write;
    assign w_ram_addr  = (r_state == IDLE) ? memory_address : r_addr;
    assign w_ram_wdata = (r_state == IDLE) ? memory_in : r_wdata;
    assign w_ram_we    = w_commit && w_is_write;
    assign w_ram_re    = w_commit && !w_is_write;

    sync_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // NOTE: all state here is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_perr     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= memory_address;
                        r_wdata <= memory_in;
                        r_write <= memory_write_signal;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        if (memory_read_signal && memory_write_signal) begin
                            r_perr <= 1'b1;
                        end
                        if (ZERO_WAIT) begin
                            r_state <= ACK;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_LAST;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ACK;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_ram_re) begin
                r_rd_valid <= 1'b1;
            end
        end
    end

    // The RAM read register has no reset, so output zero until a read has landed since reset.
    assign memory_out     = r_rd_valid ? w_ram_rdata : '0;
    assign memory_ready   = r_ready;
    assign busy           = r_busy;
    assign protocol_error = r_perr;

endmodule
